// File: rtl/decode_stage_pipe.sv
// ============================================================================
// Module   : decode_stage_pipe
// Brief    : MIPS decode stage: register file with WB bypass, early beq/bne
//            resolution, operand forwarding and an ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic            branch_i,
    input  logic            bne_i,
    input  logic [1:0]      fwd_rs_sel_i,
    input  logic [1:0]      fwd_rt_sel_i,
    input  logic [XLEN-1:0] alu_out_m_i,
    input  logic            wb_en_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            branch_taken_o,
    output logic [XLEN-1:0] pc_branch_o,
    output logic            valid_o,
    output logic [5:0]      op_o,
    output logic [5:0]      funct_o,
    output logic [4:0]      rs_o,
    output logic [4:0]      rt_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [XLEN-1:0] sign_imm_o,
    output logic [XLEN-1:0] shamt_o
);

    logic [XLEN-1:0] r_regs [NREG];

    logic [AW-1:0]   w_ra1;
    logic [AW-1:0]   w_ra2;
    logic [XLEN-1:0] w_rf1;
    logic [XLEN-1:0] w_rf2;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_sign_imm;
    logic [XLEN-1:0] w_shamt;
    logic            w_wr_en;

    // Read addresses drop the instruction bits above AW
    assign w_ra1   = instr_i[21 +: AW];
    assign w_ra2   = instr_i[16 +: AW];
    assign w_wr_en = wb_en_i && !((ZERO_REG != 0) && (wb_addr_i == '0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Write-first read: the WB value is visible in the cycle it is written
    function automatic logic [XLEN-1:0] rf_read(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored
    );
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end else if (wb_en_i && (addr == wb_addr_i)) begin
            return wb_data_i;
        end else begin
            return stored;
        end
    endfunction

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_val
    );
        case (sel)
            2'd1:    return alu_out_m_i;
            2'd2:    return wb_data_i;
            default: return rf_val;
        endcase
    endfunction

    always_comb begin
        w_rf1  = rf_read(w_ra1, r_regs[w_ra1]);
        w_rf2  = rf_read(w_ra2, r_regs[w_ra2]);
        w_op_a = fwd_mux(fwd_rs_sel_i, w_rf1);
        w_op_b = fwd_mux(fwd_rt_sel_i, w_rf2);
    end

    assign w_sign_imm     = XLEN'($signed(instr_i[15:0]));
    assign w_shamt        = XLEN'(instr_i[10:6]);
    assign branch_taken_o = valid_i & branch_i & ((w_op_a == w_op_b) ^ bne_i);
    assign pc_branch_o    = pc_plus4_i + (w_sign_imm << 2);

    // ID/EX register: flush beats stall
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || flush_i) begin
            valid_o    <= 1'b0;
            op_o       <= '0;
            funct_o    <= '0;
            rs_o       <= '0;
            rt_o       <= '0;
            rd_o       <= '0;
            rd1_o      <= '0;
            rd2_o      <= '0;
            sign_imm_o <= '0;
            shamt_o    <= '0;
        end else if (!stall_i) begin
            valid_o    <= valid_i;
            op_o       <= instr_i[31:26];
            funct_o    <= instr_i[5:0];
            rs_o       <= instr_i[25:21];
            rt_o       <= instr_i[20:16];
            rd_o       <= instr_i[15:11];
            rd1_o      <= w_op_a;
            rd2_o      <= w_op_b;
            sign_imm_o <= w_sign_imm;
            shamt_o    <= w_shamt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
// ============================================================================
// Module   : tb_decode_stage_pipe
// Brief    : Scoreboard bench for decode_stage_pipe (32/32 and 16/8 builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage_pipe;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] simm;
        logic [31:0] shamt;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit, 32-register instance
    logic        valid_i = 0, branch_i = 0, bne_i = 0, wb_en = 0, stall = 0, flush = 0;
    logic [31:0] instr = 0, pc4 = 0, alu_m = 0, wb_data = 0;
    logic [1:0]  fwd_rs = 0, fwd_rt = 0;
    logic [4:0]  wb_addr = 0;
    logic        taken, valid_o;
    logic [31:0] pc_br, rd1, rd2, simm, shamt;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;

    decode_stage_pipe #(.XLEN(32), .NREG(32), .ZERO_REG(1)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .instr_i(instr), .pc_plus4_i(pc4),
        .branch_i(branch_i), .bne_i(bne_i), .fwd_rs_sel_i(fwd_rs), .fwd_rt_sel_i(fwd_rt),
        .alu_out_m_i(alu_m), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .stall_i(stall), .flush_i(flush), .branch_taken_o(taken), .pc_branch_o(pc_br),
        .valid_o(valid_o), .op_o(op), .funct_o(funct), .rs_o(rs), .rt_o(rt), .rd_o(rd),
        .rd1_o(rd1), .rd2_o(rd2), .sign_imm_o(simm), .shamt_o(shamt)
    );

    // 16-bit, 8-register instance
    logic        s_valid_i = 0, s_wb_en = 0;
    logic [31:0] s_instr = 0;
    logic [15:0] s_pc4 = 0, s_wb_data = 0;
    logic [2:0]  s_wb_addr = 0;
    logic        s_taken, s_valid_o;
    logic [15:0] s_pc_br, s_rd1, s_rd2, s_simm, s_shamt;
    logic [5:0]  s_op, s_funct;
    logic [4:0]  s_rs, s_rt, s_rd;

    decode_stage_pipe #(.XLEN(16), .NREG(8), .ZERO_REG(1)) dut_s (
        .clk_i(clk), .rst_i(rst), .valid_i(s_valid_i), .instr_i(s_instr), .pc_plus4_i(s_pc4),
        .branch_i(1'b0), .bne_i(1'b0), .fwd_rs_sel_i(2'd0), .fwd_rt_sel_i(2'd0),
        .alu_out_m_i(16'h0), .wb_en_i(s_wb_en), .wb_addr_i(s_wb_addr), .wb_data_i(s_wb_data),
        .stall_i(1'b0), .flush_i(1'b0), .branch_taken_o(s_taken), .pc_branch_o(s_pc_br),
        .valid_o(s_valid_o), .op_o(s_op), .funct_o(s_funct), .rs_o(s_rs), .rt_o(s_rt),
        .rd_o(s_rd), .rd1_o(s_rd1), .rd2_o(s_rd2), .sign_imm_o(s_simm), .shamt_o(s_shamt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] e_op, input logic [5:0] e_funct,
                        input logic [4:0] e_rs, input logic [4:0] e_rt, input logic [4:0] e_rd,
                        input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                        input logic [31:0] e_simm, input logic [31:0] e_shamt);
        exp_t e;
        e = '{e_op, e_funct, e_rs, e_rt, e_rd, e_rd1, e_rd2, e_simm, e_shamt};
        exp_q.push_back(e);
    endtask

    // Monitor: every valid ID/EX output must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 128'(valid_o), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("fields", 128'({op, funct, rs, rt, rd}), 128'({e.op, e.funct, e.rs, e.rt, e.rd}));
                    check("rd1", 128'(rd1), 128'(e.rd1));
                    check("rd2", 128'(rd2), 128'(e.rd2));
                    check("imm", 128'({simm, shamt}), 128'({e.simm, e.shamt}));
                end
            end
        end
    end

    initial begin
        // Reset state
        tick(); tick();
        check("reset_valid", 128'(valid_o), 128'(0));
        check("reset_rd1", 128'(rd1), 128'(0));
        rst = 0;

        // Narrow build: rs=9 aliases r1, imm 0x8000 stays 0x8000, target wraps
        s_wb_en = 1; s_wb_addr = 3'd1; s_wb_data = 16'h0AB1;
        tick();
        s_wb_en = 0;
        s_instr = {6'h08, 5'd9, 5'd0, 16'h8000}; s_valid_i = 1; s_pc4 = 16'h0010;
        #1;
        check("s_pc_branch", 128'(s_pc_br), 128'(16'h0010));
        tick();
        s_valid_i = 0;
        check("s_valid", 128'(s_valid_o), 128'(1));
        check("s_rd1_alias", 128'(s_rd1), 128'(16'h0AB1));
        check("s_sign_imm", 128'(s_simm), 128'(16'h8000));
        check("s_rs_field", 128'(s_rs), 128'(5'd9));

        // WB bypass into r3 in the same cycle it is written
        valid_i = 1;
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
        instr = {6'h00, 5'd3, 5'd0, 5'd4, 5'd5, 6'h20};
        push(6'h00, 6'h20, 5'd3, 5'd0, 5'd4, 32'hDEADBEEF, 32'h0, 32'h2160, 32'h5);
        tick();

        // Write to r0 is ignored and r0 reads 0 even when bypassed
        wb_addr = 5'd0; wb_data = 32'h1234;
        instr = {6'h00, 5'd0, 5'd3, 16'h0000};
        push(6'h00, 6'h00, 5'd0, 5'd3, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
        tick();

        wb_addr = 5'd1; wb_data = 32'h10;
        instr = {6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h2A};
        push(6'h00, 6'h2A, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h2A, 32'h0);
        tick();
        wb_en = 0;

        // beq with rt forwarded from M
        instr = {6'h04, 5'd1, 5'd2, 16'hFFFF};
        branch_i = 1; fwd_rt = 2'd1; alu_m = 32'h10; pc4 = 32'h100;
        #1;
        check("beq_taken", 128'(taken), 128'(1));
        check("beq_target", 128'(pc_br), 128'(32'hFC));
        bne_i = 1;
        #1;
        check("bne_not_taken", 128'(taken), 128'(0));
        bne_i = 0; valid_i = 0;
        #1;
        check("invalid_not_taken", 128'(taken), 128'(0));
        valid_i = 1; bne_i = 1;
        push(6'h04, 6'h3F, 5'd1, 5'd2, 5'd31, 32'h10, 32'h10, 32'hFFFFFFFF, 32'h1F);
        tick();
        branch_i = 0; bne_i = 0;

        // rs from WB data, rt from regfile via select 3
        fwd_rs = 2'd2; fwd_rt = 2'd3; wb_data = 32'h55;
        instr = {6'h00, 5'd1, 5'd3, 5'd2, 5'd0, 6'h20};
        push(6'h00, 6'h20, 5'd1, 5'd3, 5'd2, 32'h55, 32'hDEADBEEF, 32'h1020, 32'h0);
        tick();
        fwd_rs = 2'd0; fwd_rt = 2'd0;

        // Capture A, then hold it for three stalled cycles with B on the inputs
        instr = {6'h23, 5'd3, 5'd1, 16'h0008};
        push(6'h23, 6'h08, 5'd3, 5'd1, 5'd0, 32'hDEADBEEF, 32'h10, 32'h8, 32'h0);
        tick();
        stall = 1;
        instr = {6'h2B, 5'd2, 5'd2, 16'h7777};
        wb_en = 1; wb_addr = 5'd5; wb_data = 32'h77;
        for (int i = 0; i < 3; i++) begin
            push(6'h23, 6'h08, 5'd3, 5'd1, 5'd0, 32'hDEADBEEF, 32'h10, 32'h8, 32'h0);
            tick();
            wb_en = 0;
        end

        // Flush together with stall gives a bubble
        flush = 1;
        tick();
        check("flush_valid", 128'(valid_o), 128'(0));
        check("flush_fields", {op, funct, rs, rt, rd, rd1, rd2, simm[15:0], shamt[4:0]}, 128'(0));
        flush = 0; stall = 0;

        // r5 was written while stalled
        instr = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h21};
        push(6'h00, 6'h21, 5'd5, 5'd0, 5'd6, 32'h77, 32'h0, 32'h3021, 32'h0);
        tick();

        // Asynchronous reset mid-run; a write during reset is lost
        @(negedge clk);
        #1;
        rst = 1;
        wb_en = 1; wb_addr = 5'd7; wb_data = 32'h99;
        #1;
        check("async_rst_valid", 128'(valid_o), 128'(0));
        check("async_rst_rd1", 128'(rd1), 128'(0));
        tick();
        rst = 0; wb_en = 0;
        instr = {6'h00, 5'd5, 5'd7, 16'h0000};
        push(6'h00, 6'h00, 5'd5, 5'd7, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        valid_i = 0;
        tick(); tick();

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised decode stage for the pipelined MIPS core. It holds the register file, resolves beq/bne early in decode, and selects operand forwarding from M or WB. Decoded fields are captured in a built-in ID/EX pipeline register with stall (hold) and flush (bubble) control. It sits between the IF/ID register and the execute stage and drives branch redirect back to fetch in the same cycle.

## Interface
- XLEN, 32, datapath width (≥16; immediates sign-extend from bit 15 to XLEN)
- NREG, 32, architectural registers (power of two, 2..32); AW = $clog2(NREG)
- ZERO_REG, 1, 1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; **asynchronous, active-high**
- valid_i  in  1  instr_i/pc_plus4_i hold a real instruction
- instr_i  in  32  instruction from IF/ID
- pc_plus4_i  in  XLEN  PC+4 of that instruction
- branch_i  in  1  instruction is a conditional branch
- bne_i  in  1  branch on not-equal (else equal); ignored when branch_i=0
- fwd_rs_sel_i  in  2  rs source: 0 regfile, 1 alu_out_m_i, 2 wb_data_i, 3 regfile
- fwd_rt_sel_i  in  2  rt source, same encoding
- alu_out_m_i  in  XLEN  ALU result currently in M
- wb_en_i  in  1  register write enable from WB
- wb_addr_i  in  AW  WB destination
- wb_data_i  in  XLEN  WB result
- stall_i  in  1  hold ID/EX register
- flush_i  in  1  load bubble into ID/EX register
- branch_taken_o  out  1  combinational redirect request
- pc_branch_o  out  XLEN  combinational branch target
- valid_o  out  1  registered: ID/EX holds a real instruction
- op_o  out  6  registered instr[31:26]
- funct_o  out  6  registered instr[5:0]
- rs_o, rt_o, rd_o  out  5 each  registered instr[25:21], [20:16], [15:11]
- rd1_o, rd2_o  out  XLEN  registered forwarded operands
- sign_imm_o  out  XLEN  registered sign-extended instr[15:0]
- shamt_o  out  XLEN  registered zero-extended instr[10:6]

## Operation
- Register file: NREG×XLEN with two read ports (addresses instr[25:21], instr[20:16] truncated to AW bits) and one write port. A write occurs on the clock edge when wb_en_i=1, except to reg 0 when ZERO_REG=1.
- Write-first bypass: a read address equal to wb_addr_i with wb_en_i=1 returns wb_data_i in the same cycle. Reg 0 with ZERO_REG=1 always returns 0.
- Forward mux per operand per the fwd_*_sel_i encoding yields opA and opB. The equality compare uses the full XLEN width.
- branch_taken_o = valid_i & branch_i & ((opA==opB) ^ bne_i).
- pc_branch_o = pc_plus4_i + (sext(instr[15:0]) << 2), computed modulo 2^XLEN.
- ID/EX register update, in priority order:
  - flush_i=1: bubble. valid_o=0 and all other outputs 0.
  - else stall_i=1: all outputs hold.
  - else: capture valid_i, fields, opA→rd1_o, opB→rd2_o, and the immediates.
- Register-file writes are never blocked by stall_i or flush_i.
- flush_i together with stall_i produces a bubble (flush wins).

## Timing
- Reset (async assert, released sync to clk_i): all registered outputs 0, valid_o=0, all register-file entries 0.
- Reset asserted mid-operation clears state immediately. Writes in the cycle of reset are lost.
- Decode to ID/EX outputs: 1-cycle latency.
- branch_taken_o and pc_branch_o are combinational in the decode cycle: 0 cycles, valid before the same edge.
- WB write and same-cycle read are bypassed, so there is no extra latency for WB→ID.
- When stalled, branch_taken_o still reflects current inputs. The hazard unit must gate redirect on stall.

## Test plan
- Reset: rst_i=1 mid-run. Immediately valid_o=0, rd1_o=0. Afterwards read of r5 returns 0.
- Write/read bypass: wb_en_i=1, wb_addr_i=3, wb_data_i=0xDEAD_BEEF, instr rs=3, valid_i=1. Next edge: rd1_o=0xDEADBEEF. Write to r0 with ZERO_REG=1 reads back 0.
- Branch: beq rs=1 (0x10), rt=2 via fwd_rt_sel_i=1 with alu_out_m_i=0x10, imm=0xFFFF, pc_plus4_i=0x100. Result: branch_taken_o=1, pc_branch_o=0xFC. With bne_i=1: branch_taken_o=0.
- Stall/flush: capture instr A, then stall_i=1 for 3 cycles with instr B on inputs. Outputs remain A. flush_i=1 with stall_i=1: valid_o=0, all fields 0.
- Parameter sweep: XLEN=16, NREG=8. Immediate 0x8000 gives sign_imm_o=0x8000. Address bits above AW are ignored: rs=9 reads r1.
